// File: rtl/bp_be_prefetch_inject_ctrl.sv
// Prefetch injection sequencer for the BE dispatch slot.
// A confirmed striding load trains a short burst of prefetch vaddrs that are
// offered one at a time to the scheduler. Bursts stop at the page boundary of
// the training access, at the burst length, or on a pipeline flush. In-flight
// prefetches are counted until the memory pipe reports them done.
module bp_be_prefetch_inject_ctrl #(
   parameter int vaddr_width_p     = 39,
   parameter int stride_width_p    = 8,
   parameter int iter_width_p      = 8,
   parameter int max_burst_p       = 4,
   parameter int max_outstanding_p = 2,
   parameter int page_offset_p     = 12
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      train_v_i,
   input  logic [vaddr_width_p-1:0]  base_vaddr_i,
   input  logic [stride_width_p-1:0] stride_i,
   input  logic [iter_width_p-1:0]   iters_i,
   input  logic                      flush_i,
   output logic                      pf_v_o,
   output logic [vaddr_width_p-1:0]  pf_vaddr_o,
   input  logic                      pf_yumi_i,
   input  logic                      pf_done_i,
   output logic                      busy_o
);

   localparam int out_w = $clog2(max_outstanding_p + 1);
   localparam int tag_w = vaddr_width_p - page_offset_p;

   localparam logic [out_w-1:0]        max_out_c   = out_w'(max_outstanding_p);
   localparam logic [iter_width_p-1:0] max_burst_c = iter_width_p'(max_burst_p);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e                    state_reg,       state_next;
   logic [vaddr_width_p-1:0]  next_addr_reg,   next_addr_next;
   logic [vaddr_width_p-1:0]  stride_reg,      stride_next;
   logic [iter_width_p-1:0]   remaining_reg,   remaining_next;
   logic [tag_w-1:0]          page_tag_reg,    page_tag_next;
   logic [out_w-1:0]          outstanding_reg, outstanding_next;
   logic                      pf_v_reg,        pf_v_next;
   logic                      busy_reg,        busy_next;

   logic [vaddr_width_p-1:0]  stride_sext;
   logic [iter_width_p-1:0]   burst_len;
   logic                      train_ok;
   logic                      off_page;

   assign stride_sext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
   assign burst_len   = (iters_i < max_burst_c) ? iters_i : max_burst_c;
   assign train_ok    = train_v_i && (stride_i != '0) && (iters_i != '0);
   assign off_page    = (next_addr_reg[vaddr_width_p-1:page_offset_p] != page_tag_reg);

   // Next-state computation for the sequencer, the burst bookkeeping and the
   // in-flight counter; outputs are derived from the post-update values so
   // they can be registered without adding a cycle of latency.
   always_comb begin
      state_next       = state_reg;
      next_addr_next   = next_addr_reg;
      stride_next      = stride_reg;
      remaining_next   = remaining_reg;
      page_tag_next    = page_tag_reg;
      outstanding_next = outstanding_reg;

      // A consume and a completion in the same cycle cancel out; a stray
      // completion with nothing in flight is dropped rather than underflowing.
      if (pf_yumi_i && !pf_done_i) begin
         outstanding_next = outstanding_reg + out_w'(1);
      end else if (!pf_yumi_i && pf_done_i && (outstanding_reg != '0)) begin
         outstanding_next = outstanding_reg - out_w'(1);
      end

      if (flush_i) begin
         // Flush abandons the burst but keeps counting what is already in flight.
         state_next     = IDLE;
         remaining_next = '0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (train_ok) begin
                  next_addr_next = base_vaddr_i + stride_sext;
                  stride_next    = stride_sext;
                  remaining_next = burst_len;
                  page_tag_next  = base_vaddr_i[vaddr_width_p-1:page_offset_p];
                  state_next     = ISSUE;
               end
            end
            ISSUE: begin
               if (pf_yumi_i) begin
                  next_addr_next = next_addr_reg + stride_reg;
                  remaining_next = remaining_reg - iter_width_p'(1);
                  if (remaining_reg == iter_width_p'(1)) begin
                     state_next = DRAIN;
                  end
               end else if (off_page) begin
                  // Next address left the training page (either direction,
                  // including wrap-around): end the burst without offering it.
                  state_next = DRAIN;
               end
            end
            DRAIN: begin
               if (outstanding_next == '0) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end

      pf_v_next = (state_next == ISSUE)
                  && (outstanding_next < max_out_c)
                  && (next_addr_next[vaddr_width_p-1:page_offset_p] == page_tag_next);
      busy_next = (state_next != IDLE) || (outstanding_next != '0);
   end

   // State and registered outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg       <= IDLE;
         next_addr_reg   <= '0;
         stride_reg      <= '0;
         remaining_reg   <= '0;
         page_tag_reg    <= '0;
         outstanding_reg <= '0;
         pf_v_reg        <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         next_addr_reg   <= next_addr_next;
         stride_reg      <= stride_next;
         remaining_reg   <= remaining_next;
         page_tag_reg    <= page_tag_next;
         outstanding_reg <= outstanding_next;
         pf_v_reg        <= pf_v_next;
         busy_reg        <= busy_next;
      end
   end

   assign pf_v_o     = pf_v_reg;
   assign pf_vaddr_o = next_addr_reg;
   assign busy_o     = busy_reg;

   // The scheduler may only consume a request that is currently offered.
   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      pf_yumi_i |-> pf_v_o);

   // A completion with nothing in flight indicates a bookkeeping error upstream.
   a_done_needs_outstanding: assert property (@(posedge clk_i) disable iff (reset_i)
      (pf_done_i && !pf_yumi_i) |-> (outstanding_reg != '0));

endmodule

// File: tb/tb_bp_be_prefetch_inject_ctrl.sv
// Directed bench for the prefetch injection sequencer. A queue-based model
// plans each burst's address list up front and is compared every cycle.
module tb_bp_be_prefetch_inject_ctrl;

   logic        clk_i;
   logic        reset_i;
   logic        train_v_i;
   logic [38:0] base_vaddr_i;
   logic [7:0]  stride_i;
   logic [7:0]  iters_i;
   logic        flush_i;
   logic        pf_v_o;
   logic [38:0] pf_vaddr_o;
   logic        pf_yumi_i;
   logic        pf_done_i;
   logic        busy_o;

   bp_be_prefetch_inject_ctrl dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .train_v_i    (train_v_i),
      .base_vaddr_i (base_vaddr_i),
      .stride_i     (stride_i),
      .iters_i      (iters_i),
      .flush_i      (flush_i),
      .pf_v_o       (pf_v_o),
      .pf_vaddr_o   (pf_vaddr_o),
      .pf_yumi_i    (pf_yumi_i),
      .pf_done_i    (pf_done_i),
      .busy_o       (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // ---------------- model ----------------
   logic [38:0] m_q[$];     // planned prefetch addresses not yet consumed
   bit          m_live;     // a burst is in progress (sequencer not idle)
   bit          m_trunc;    // current burst was cut short by the page boundary
   int          m_tail;     // cycles left before a page-cut burst may close
   int          m_outst;    // prefetches in flight
   bit          model_ready = 0;

   task automatic plan_burst(input logic [38:0] base, input logic [7:0] stride, input logic [7:0] iters);
      int          n;
      logic [38:0] a;
      logic [38:0] s;
      n = (iters < 8'd4) ? int'(iters) : 4;
      a = base;
      s = {{31{stride[7]}}, stride};
      m_q.delete();
      m_trunc = 0;
      for (int k = 0; k < n; k++) begin
         a = a + s;
         if (a[38:12] != base[38:12]) begin
            m_trunc = 1;
            break;
         end
         m_q.push_back(a);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk_i);
         if (reset_i) begin
            m_q.delete();
            m_live = 0; m_trunc = 0; m_tail = 0; m_outst = 0;
         end else begin
            if (pf_yumi_i && pf_done_i) begin
            end else if (pf_yumi_i) begin
               m_outst++;
            end else if (pf_done_i && m_outst > 0) begin
               m_outst--;
            end
            if (flush_i) begin
               m_live = 0; m_tail = 0; m_q.delete();
            end else if (!m_live) begin
               if (train_v_i && stride_i != 0 && iters_i != 0) begin
                  plan_burst(base_vaddr_i, stride_i, iters_i);
                  m_live = 1;
                  m_tail = (m_q.size() == 0) ? 2 : 0;
               end
            end else begin
               if (m_tail > 0) m_tail--;
               if (pf_yumi_i && m_q.size() > 0) begin
                  void'(m_q.pop_front());
                  if (m_q.size() == 0 && m_trunc) m_tail = 2;
               end
               if (m_q.size() == 0 && m_tail == 0 && m_outst == 0) m_live = 0;
            end
         end
         model_ready = 1;
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk_i);
         if (model_ready) begin
            logic exp_v;
            exp_v = m_live && (m_q.size() > 0) && (m_outst < 2);
            check("pf_v", 64'(pf_v_o), 64'(exp_v));
            check("busy", 64'(busy_o), 64'(m_live || m_outst != 0));
            if (exp_v) check("pf_vaddr", 64'(pf_vaddr_o), 64'(m_q[0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   bit          auto_yumi;
   bit          drain_mode;
   int          done_lat;
   int          done_q[$];
   logic [38:0] issued[$];
   logic [38:0] exp_q[$];

   task automatic tick();
      @(posedge clk_i);
      #2;
      pf_done_i = 1'b0;
      for (int i = 0; i < done_q.size(); i++) done_q[i]--;
      if (done_q.size() > 0 && done_q[0] <= 0) begin
         void'(done_q.pop_front());
         pf_done_i = 1'b1;
      end
      if (drain_mode && m_outst > 0) pf_done_i = 1'b1;
      pf_yumi_i = auto_yumi && pf_v_o;
      if (pf_yumi_i) begin
         issued.push_back(pf_vaddr_o);
         $display("issue vaddr=0x%0h", pf_vaddr_o);
         if (done_lat > 0) done_q.push_back(done_lat);
      end
   endtask

   task automatic clear_modes();
      auto_yumi = 0; drain_mode = 0; done_lat = 0;
      done_q.delete(); issued.delete();
      pf_yumi_i = 0; pf_done_i = 0; flush_i = 0; train_v_i = 0;
   endtask

   task automatic train(input logic [38:0] base, input logic [7:0] stride, input logic [7:0] iters);
      train_v_i = 1; base_vaddr_i = base; stride_i = stride; iters_i = iters;
      tick();
      train_v_i = 0;
   endtask

   task automatic wait_idle(input string nm, input int max);
      bit ok;
      ok = 0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (!busy_o && !pf_yumi_i && !pf_done_i) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_timeout: busy_o=%0b expected 0 within %0d cycles", nm, busy_o, max);
      end
   endtask

   task automatic check_issued(input string nm);
      int n;
      check({nm, "_count"}, 64'(issued.size()), 64'(exp_q.size()));
      n = (issued.size() < exp_q.size()) ? issued.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_addr%0d", nm, i), 64'(issued[i]), 64'(exp_q[i]));
   endtask

   initial begin
      reset_i = 1; base_vaddr_i = '0; stride_i = '0; iters_i = '0;
      clear_modes();
      repeat (3) tick();
      check("reset_pf_v", 64'(pf_v_o), 64'd0);
      check("reset_pf_vaddr", 64'(pf_vaddr_o), 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
      reset_i = 0;
      tick();

      // Full burst, consume every cycle, completions two cycles later.
      clear_modes(); auto_yumi = 1; done_lat = 2;
      train(39'h1000, 8'd8, 8'd10);
      wait_idle("t1", 40);
      exp_q = '{39'h1008, 39'h1010, 39'h1018, 39'h1020};
      check_issued("t1");

      // No completions: stalls at two in flight, one completion releases 0x1018.
      clear_modes(); auto_yumi = 1;
      train(39'h1000, 8'd8, 8'd10);
      repeat (5) tick();
      check("t2_stall_v", 64'(pf_v_o), 64'd0);
      check("t2_stall_busy", 64'(busy_o), 64'd1);
      pf_done_i = 1;
      tick();
      check("t2_resume_v", 64'(pf_v_o), 64'd1);
      check("t2_resume_addr", 64'(pf_vaddr_o), 64'h1018);
      drain_mode = 1;
      wait_idle("t2", 40);
      exp_q = '{39'h1008, 39'h1010, 39'h1018, 39'h1020};
      check_issued("t2");

      // First address already crosses the page: nothing is offered.
      clear_modes(); auto_yumi = 1; done_lat = 2;
      train(39'h1FF0, 8'd16, 8'd5);
      check("t3_busy_after_train", 64'(busy_o), 64'd1);
      wait_idle("t3", 20);
      exp_q = '{};
      check_issued("t3");

      // Negative stride stops at the lower page boundary.
      clear_modes(); auto_yumi = 1; done_lat = 2;
      train(39'h1010, 8'hF8, 8'd10);
      wait_idle("t4", 40);
      exp_q = '{39'h1008, 39'h1000};
      check_issued("t4");

      // Flush after the first consume: idle at once, busy until its completion.
      clear_modes(); auto_yumi = 1;
      train(39'h1000, 8'd8, 8'd10);
      auto_yumi = 0;
      tick();
      flush_i = 1;
      tick();
      flush_i = 0;
      check("t5_flush_v", 64'(pf_v_o), 64'd0);
      check("t5_flush_busy", 64'(busy_o), 64'd1);
      repeat (3) tick();
      check("t5_hold_busy", 64'(busy_o), 64'd1);
      pf_done_i = 1;
      tick();
      check("t5_done_busy", 64'(busy_o), 64'd0);
      exp_q = '{39'h1008};
      check_issued("t5");

      // Flush in the same cycle as a consume still counts that prefetch.
      clear_modes(); auto_yumi = 1;
      train(39'h2000, 8'd4, 8'd3);
      auto_yumi = 0;
      flush_i = 1;
      tick();
      flush_i = 0;
      check("t6_flush_yumi_busy", 64'(busy_o), 64'd1);
      check("t6_flush_yumi_v", 64'(pf_v_o), 64'd0);
      pf_done_i = 1;
      tick();
      check("t6_done_busy", 64'(busy_o), 64'd0);

      // Flush dominates a same-cycle training.
      clear_modes();
      train_v_i = 1; base_vaddr_i = 39'h3000; stride_i = 8'd8; iters_i = 8'd4; flush_i = 1;
      tick();
      train_v_i = 0; flush_i = 0;
      tick();
      check("t7_flush_train_busy", 64'(busy_o), 64'd0);

      // Consume + completion at one in flight leaves the count at one.
      clear_modes(); auto_yumi = 1;
      train(39'h1000, 8'd8, 8'd10);
      tick();
      pf_done_i = 1;
      auto_yumi = 0;
      tick();
      check("t8_same_cycle_v", 64'(pf_v_o), 64'd1);
      check("t8_same_cycle_addr", 64'(pf_vaddr_o), 64'h1018);
      auto_yumi = 1; drain_mode = 1;
      wait_idle("t8", 40);

      // Degenerate trainings are ignored.
      clear_modes();
      train(39'h1000, 8'd0, 8'd5);
      tick();
      check("t9_stride0_busy", 64'(busy_o), 64'd0);
      train(39'h1000, 8'd8, 8'd0);
      tick();
      check("t9_iters0_busy", 64'(busy_o), 64'd0);

      // Reset in the middle of a burst.
      clear_modes();
      train(39'h5000, 8'd8, 8'd4);
      tick();
      reset_i = 1;
      tick();
      check("t10_reset_v", 64'(pf_v_o), 64'd0);
      check("t10_reset_busy", 64'(busy_o), 64'd0);
      check("t10_reset_vaddr", 64'(pf_vaddr_o), 64'd0);
      reset_i = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
